// File: rtl/ti_anf_pkg.sv
// Shared sizing helpers for the quadratic ANF evaluator: term count, coefficient
// word count and the packed index of a degree-2 monomial x[i]&x[k].
package ti_anf_pkg;

  localparam int COEF_WORD_W = 32;

  function automatic int anf_terms(input int n_in);
    return 1 + n_in + (n_in * (n_in - 1)) / 2;
  endfunction

  function automatic int anf_words(input int terms);
    return (terms + COEF_WORD_W - 1) / COEF_WORD_W;
  endfunction

  // Pairs (i,k), i<k, enumerated row-major: (0,1),(0,2)...(0,n-1),(1,2)...
  function automatic int pair_index(input int i, input int k, input int n_in);
    return (i * (2 * n_in - i - 1)) / 2 + (k - i - 1);
  endfunction

endpackage

// File: rtl/ti_anf_row.sv
// One component function: XOR of the constant, linear and pairwise AND terms
// selected by a TERMS-bit coefficient vector. Purely combinational.
module ti_anf_row
  import ti_anf_pkg::*;
#(
  parameter int N_IN  = 16,
  parameter int TERMS = anf_terms(N_IN)
) (
  input  logic [TERMS-1:0] i_coef,
  input  logic [N_IN-1:0]  i_x,
  output logic             o_y
);

  logic w_acc;

  always_comb begin
    w_acc = i_coef[0];
    for (int i = 0; i < N_IN; i++) begin
      w_acc = w_acc ^ (i_coef[1 + i] & i_x[i]);
    end
    for (int i = 0; i < N_IN - 1; i++) begin
      for (int k = i + 1; k < N_IN; k++) begin
        w_acc = w_acc ^ (i_coef[1 + N_IN + pair_index(i, k, N_IN)] & i_x[i] & i_x[k]);
      end
    end
  end

  assign o_y = w_acc;

endmodule

// File: rtl/ti_quad_anf_eval.sv
// Two-stage programmable evaluator of N_OUT quadratic ANFs over N_IN shared bits.
// Stage A registers the shares, stage B registers the evaluated outputs.
module ti_quad_anf_eval
  import ti_anf_pkg::*;
#(
  parameter int  N_IN   = 16,
  parameter int  N_OUT  = 8,
  localparam int TERMS  = anf_terms(N_IN),
  localparam int WORDS  = anf_words(TERMS),
  localparam int NWORDS = N_OUT * WORDS,
  localparam int AW     = $clog2(NWORDS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [N_IN-1:0]        s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [N_OUT-1:0]       m_data,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [COEF_WORD_W-1:0] cfg_wdata,
  output logic                   cfg_ready,
  output logic                   cfg_err
);

  // Coefficient bits at or above TERMS never contribute, so only TERMS bits per row are kept.
  logic [TERMS-1:0] r_coef [N_OUT];

  logic             r_vld_p0;
  logic [N_IN-1:0]  r_x_p0;
  logic             r_vld_p1;
  logic [N_OUT-1:0] r_y_p1;
  logic             r_cfg_err;

  logic             w_cfg_in_range;
  logic             w_cfg_wr;
  logic             w_adv_p1;
  logic             w_s_acc;
  logic [N_OUT-1:0] w_y;

  assign cfg_ready      = !r_vld_p0 && !r_vld_p1;
  assign w_cfg_in_range = ({1'b0, cfg_addr} < (AW + 1)'(NWORDS));
  assign w_cfg_wr       = cfg_we && cfg_ready && w_cfg_in_range;

  assign w_adv_p1 = r_vld_p0 && (!r_vld_p1 || m_ready);
  assign s_ready  = (!r_vld_p0 || w_adv_p1) && !w_cfg_wr;
  assign w_s_acc  = s_valid && s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < N_OUT; j++) begin
        r_coef[j] <= '0;
      end
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        for (int t = 0; t < TERMS; t++) begin
          if (w_cfg_wr && (cfg_addr == AW'(j * WORDS + t / COEF_WORD_W))) begin
            r_coef[j][t] <= cfg_wdata[t % COEF_WORD_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_vld_p0  <= w_s_acc || (r_vld_p0 && !w_adv_p1);
      r_vld_p1  <= r_vld_p0 || (r_vld_p1 && !m_ready);
      r_cfg_err <= cfg_we && cfg_ready && !w_cfg_in_range;
    end
  end

  // Stage A: share register, the glitch barrier ahead of the nonlinear layer
  always_ff @(posedge clk) begin
    if (w_s_acc) begin
      r_x_p0 <= s_data;
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_row
    ti_anf_row #(
      .N_IN  (N_IN),
      .TERMS (TERMS)
    ) u_row (
      .i_coef (r_coef[j]),
      .i_x    (r_x_p0),
      .o_y    (w_y[j])
    );
  end

  // Stage B: evaluated component bits, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (w_adv_p1) begin
      r_y_p1 <= w_y;
    end
  end

  assign m_valid = r_vld_p1;
  assign m_data  = r_vld_p1 ? r_y_p1 : '0;
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_ti_quad_anf_eval.sv
// Directed bench for ti_quad_anf_eval at N_IN=16, N_OUT=8 with hand-computed results.
module tb_ti_quad_anf_eval;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        cfg_ready;
  logic        cfg_err;

  int n_chk = 0;
  int n_bad = 0;

  logic [15:0] in_q[$];
  logic [7:0]  exp_q[$];

  ti_quad_anf_eval #(.N_IN(16), .N_OUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [5:0] addr, input logic [31:0] data);
    int n = 0;
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    #1;
    while (!cfg_ready && n < 50) begin
      tick();
      n++;
    end
    check("cfg_wait", 32'(n < 50), 32'd1);
    tick();
    cfg_we = 1'b0;
  endtask

  // Streams in_q, checks every visible result against exp_q; mode 1 toggles m_ready 1,0,0.
  task automatic run_stream(input string tag, input int mode);
    int n = in_q.size();
    int sent = 0;
    int got = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    while (got < n && cyc < 200) begin
      s_valid = (sent < n);
      s_data  = (sent < n) ? in_q[sent] : 16'h0;
      m_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      #1;
      if (prev_stall) check({tag, "_hold"}, m_data, prev_data);
      if (m_valid) check({tag, "_data"}, m_data, exp_q[got]);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (s_valid && s_ready) sent++;
      if (m_valid && m_ready) got++;
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    check({tag, "_count"}, got, n);
    #1;
    check({tag, "_drained"}, m_valid, 1'b0);
    in_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_cfg_ready", cfg_ready, 1'b1);
    check("rst_cfg_err", cfg_err, 1'b0);

    in_q = '{16'hFFFF, 16'h1234}; exp_q = '{8'h00, 8'h00};
    run_stream("zero_coef", 0);

    // Row 0: x0 ^ x2 ^ x0&x1, then latency and per-cycle throughput
    cfg_write(6'd0, 32'h0002000A);
    s_valid = 1'b1; s_data = 16'h0001;
    #1 check("acc_s_ready", s_ready, 1'b1);
    tick();
    check("lat_not_yet", m_valid, 1'b0);
    s_data = 16'h0003;
    tick();
    check("lat_valid", m_valid, 1'b1);
    check("r0_x0001", m_data, 8'h01);
    s_data = 16'h0005;
    tick();
    check("r0_x0003", m_data, 8'h00);
    s_data = 16'h0004;
    tick();
    check("r0_x0005", m_data, 8'h00);
    check("r0_valid3", m_valid, 1'b1);
    s_valid = 1'b0;
    tick();
    check("r0_x0004", m_data, 8'h01);
    tick();
    check("r0_empty", m_valid, 1'b0);

    // Row 7: constant plus x14&x15 (term 136)
    cfg_write(6'd39, 32'h00000100);
    cfg_write(6'd35, 32'h00000001);
    in_q = '{16'hC000, 16'h4000}; exp_q = '{8'h00, 8'h80};
    run_stream("r7", 0);

    in_q  = '{16'h0001, 16'h0003, 16'hC004, 16'hC000, 16'h0005, 16'hC002};
    exp_q = '{8'h81, 8'h80, 8'h01, 8'h00, 8'h80, 8'h00};
    run_stream("bp", 1);

    // Config interlock with two beats in flight
    m_ready = 1'b0; s_valid = 1'b1; s_data = 16'h0001;
    tick();
    s_data = 16'h0004;
    tick();
    s_valid = 1'b0;
    #1;
    check("full_stall", s_ready, 1'b0);
    check("busy_cfg_ready", cfg_ready, 1'b0);
    cfg_we = 1'b1; cfg_addr = 6'd0; cfg_wdata = 32'h0;
    tick();
    tick();
    check("cfg_held_off", cfg_ready, 1'b0);
    check("busy_no_err", cfg_err, 1'b0);
    m_ready = 1'b1;
    #1;
    check("stall_release", s_ready, 1'b1);
    check("il_b1", m_data, 8'h81);
    tick();
    check("il_b2_old_coef", m_data, 8'h81);
    check("il_still_busy", cfg_ready, 1'b0);
    tick();
    check("il_empty", m_valid, 1'b0);
    check("il_ready", cfg_ready, 1'b1);
    s_valid = 1'b1; s_data = 16'h0001;
    #1 check("cfg_wins", s_ready, 1'b0);
    tick();
    cfg_we = 1'b0;
    #1 check("after_wr_s_ready", s_ready, 1'b1);
    tick();
    s_valid = 1'b0;
    tick();
    check("il_new_valid", m_valid, 1'b1);
    check("il_new_coef", m_data, 8'h80);
    tick();

    // Out-of-range write
    cfg_we = 1'b1; cfg_addr = 6'd40; cfg_wdata = 32'hFFFFFFFF;
    #1 check("err_before", cfg_err, 1'b0);
    tick();
    check("err_pulse", cfg_err, 1'b1);
    cfg_we = 1'b0;
    tick();
    check("err_clear", cfg_err, 1'b0);
    in_q = '{16'h0001, 16'hC000}; exp_q = '{8'h80, 8'h00};
    run_stream("oor_unchanged", 0);

    // Reset with a beat in stage B
    m_ready = 1'b0; s_valid = 1'b1; s_data = 16'h0000;
    tick();
    s_valid = 1'b0;
    tick();
    check("pre_rst_valid", m_valid, 1'b1);
    check("pre_rst_data", m_data, 8'h80);
    rst = 1'b1;
    tick();
    check("mid_rst_m_valid", m_valid, 1'b0);
    check("mid_rst_m_data", m_data, 8'h00);
    check("mid_rst_s_ready", s_ready, 1'b1);
    check("mid_rst_cfg_ready", cfg_ready, 1'b1);
    rst = 1'b0; m_ready = 1'b1;
    in_q = '{16'h4000, 16'h0001}; exp_q = '{8'h00, 8'h00};
    run_stream("post_rst", 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
